// File: rtl/instr_mem_pkg.sv
// Shared widths, constants and types for the instruction memory responder.
package instr_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1: feedback taps are state bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [WORD_W-1:0] OOR_DATA = 32'h0000_0000;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t            data;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus: req/adr answered by gnt, then in-order rvalid/read.
interface instr_mem_responder_if;
    import instr_mem_pkg::*;

    logic  instr_req;
    word_t instr_adr;
    logic  instr_gnt;
    logic  instr_rvalid;
    word_t instr_read;

    modport master (output instr_req, output instr_adr,
                    input  instr_gnt, input  instr_rvalid, input instr_read);
    modport slave  (input  instr_req, input  instr_adr,
                    output instr_gnt, output instr_rvalid, output instr_read);

endinterface

// File: rtl/instr_mem_resp_fifo.sv
// In-order response FIFO; each entry counts down to zero and the head leaves once it reaches it.
module instr_mem_resp_fifo
    import instr_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              push,
    input  resp_entry_t       push_entry,
    input  logic              pop,
    output logic              head_ready,
    output word_t             head_data,
    output logic [OCC_W-1:0]  occupancy
);

    resp_entry_t       entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (res) begin
            valid     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // NOTE: payload storage has no reset; the valid bits alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].cnt != '0)
                entries[i].cnt <= entries[i].cnt - 1'b1;
        end
        if (push)
            entries[wr_ptr] <= push_entry;
    end

    assign head_ready = valid[rd_ptr] && (entries[rd_ptr].cnt == '0);
    assign head_data  = entries[rd_ptr].data;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: word array, grant logic, preload port and response FIFO.
// Define INSTR_MEM_GNT_STALL_EN to add LFSR-driven random grant wait states.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int MEM_LOG_WORDS = 10,
    parameter int LATENCY       = 2,
    parameter int DEPTH         = 4
) (
    input  logic                  clk,
    input  logic                  res,
    instr_mem_responder_if.slave  bus,
    input  logic                  mem_we,
    input  word_t                 mem_wadr,
    input  word_t                 mem_wdata
);

    localparam int               OCC_W    = clog2(DEPTH) + 1;
    localparam int               WORDS    = 1 << MEM_LOG_WORDS;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    word_t                    mem [WORDS];
    logic [MEM_LOG_WORDS-1:0] rd_idx;
    logic [MEM_LOG_WORDS-1:0] wr_idx;
    logic                     rd_oor;
    logic                     wr_oor;
    logic                     stall;
    logic                     gnt;
    logic                     rvalid;
    logic                     head_ready;
    word_t                    head_data;
    logic [OCC_W-1:0]         occupancy;
    resp_entry_t              push_entry;
    logic                     unused_adr_bits;

    assign rd_idx = bus.instr_adr[MEM_LOG_WORDS+1:2];
    assign wr_idx = mem_wadr[MEM_LOG_WORDS+1:2];
    assign rd_oor = |bus.instr_adr[WORD_W-1:MEM_LOG_WORDS+2];
    assign wr_oor = |mem_wadr[WORD_W-1:MEM_LOG_WORDS+2];
    assign unused_adr_bits = ^{bus.instr_adr[1:0], mem_wadr[1:0]};

    always_ff @(posedge clk) begin
        if (!res && mem_we && !wr_oor)
            mem[wr_idx] <= mem_wdata;
    end

`ifdef INSTR_MEM_GNT_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (res) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // A full FIFO never grants, even when its head leaves in the same cycle.
    assign gnt    = bus.instr_req && (occupancy < OCC_FULL) && !res && !stall;
    assign rvalid = head_ready && !res;

    // The combinational array read sees the value from before any same-cycle preload write.
    assign push_entry.data = rd_oor ? OOR_DATA : mem[rd_idx];
    assign push_entry.cnt  = CNT_INIT;

    instr_mem_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .res        (res),
        .push       (gnt),
        .push_entry (push_entry),
        .pop        (rvalid),
        .head_ready (head_ready),
        .head_data  (head_data),
        .occupancy  (occupancy)
    );

    assign bus.instr_gnt    = gnt;
    assign bus.instr_rvalid = rvalid;
    assign bus.instr_read   = rvalid ? head_data : '0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: dut_a (LATENCY=2) and dut_b (LATENCY=8), both DEPTH=4 and 1K words.
module tb_instr_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_a, res_b, we_a, we_b;
    logic [31:0] wadr_a, wdata_a, wadr_b, wdata_b;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_a [16];

    instr_mem_responder_if bus_a();
    instr_mem_responder_if bus_b();

    instr_mem_responder #(.MEM_LOG_WORDS(10), .LATENCY(2), .DEPTH(4)) dut_a (
        .clk(clk), .res(res_a), .bus(bus_a),
        .mem_we(we_a), .mem_wadr(wadr_a), .mem_wdata(wdata_a));

    instr_mem_responder #(.MEM_LOG_WORDS(10), .LATENCY(8), .DEPTH(4)) dut_b (
        .clk(clk), .res(res_b), .bus(bus_b),
        .mem_we(we_b), .mem_wadr(wadr_b), .mem_wdata(wdata_b));

`ifdef INSTR_MEM_GNT_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (res_a) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] adr, input logic [31:0] data);
        we_a = 1'b1; wadr_a = adr; wdata_a = data;
        next();
        we_a = 1'b0;
    endtask

    task automatic load_b(input logic [31:0] adr, input logic [31:0] data);
        we_b = 1'b1; wadr_b = adr; wdata_b = data;
        next();
        we_b = 1'b0;
    endtask

    // Single read on dut_a: gnt in T, nothing in T+1, data in T+2 only.
    task automatic read_a(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus_a.instr_req = 1'b1; bus_a.instr_adr = adr;
        @(negedge clk); check({tag, "_gnt"}, 32'(bus_a.instr_gnt), 32'd1);
        next();
        bus_a.instr_req = 1'b0;
        @(negedge clk); check({tag, "_early"}, 32'(bus_a.instr_rvalid), 32'd0);
        next();
        @(negedge clk); check({tag, "_rvalid"}, 32'(bus_a.instr_rvalid), 32'd1);
        check({tag, "_read"}, bus_a.instr_read, exp);
        next();
        @(negedge clk); check({tag, "_late"}, 32'(bus_a.instr_rvalid), 32'd0);
        next();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int  gcyc[6] = '{0, 1, 2, 3, 9, 10};
        int  rcyc[6] = '{8, 9, 10, 11, 17, 18};
        int  k, r, widx;
        bit  pending, exp_g, exp_rv;

        res_a = 1'b1; res_b = 1'b1;
        we_a = 1'b0; we_b = 1'b0;
        wadr_a = '0; wdata_a = '0; wadr_b = '0; wdata_b = '0;
        bus_a.instr_req = 1'b0; bus_a.instr_adr = '0;
        bus_b.instr_req = 1'b0; bus_b.instr_adr = '0;
        next(); next();

        // Reset holds off grants even with a request present.
        bus_a.instr_req = 1'b1;
        @(negedge clk);
        check("rst_gnt", 32'(bus_a.instr_gnt), 32'd0);
        check("rst_rvalid", 32'(bus_a.instr_rvalid), 32'd0);
        check("rst_read", bus_a.instr_read, 32'd0);
        next();
        res_a = 1'b0; res_b = 1'b0; bus_a.instr_req = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid_a", 32'(bus_a.instr_rvalid), 32'd0);
        check("post_rst_read_a", bus_a.instr_read, 32'd0);
        check("post_rst_rvalid_b", 32'(bus_b.instr_rvalid), 32'd0);
        next();

        // Word 5, then an out-of-range preload that would alias onto it if not dropped.
        load_a(32'h0000_0014, 32'hDEAD_BEEF);
        load_a(32'h0000_1014, 32'hBAD0_BAD0);
        read_a("w5", 32'h0000_0014, 32'hDEAD_BEEF);

        load_a(32'h0000_0000, 32'hA5A5_A5A5);
        read_a("oor", 32'h8000_0000, 32'h0000_0000);
        read_a("w0", 32'h0000_0003, 32'hA5A5_A5A5);

        // Preload during reset is ignored.
        load_a(32'h0000_001C, 32'h7777_7777);
        res_a = 1'b1; we_a = 1'b1; wadr_a = 32'h0000_001C; wdata_a = 32'h0BAD_0BAD;
        next();
        res_a = 1'b0; we_a = 1'b0;
        read_a("rst_we", 32'h0000_001C, 32'h7777_7777);

        // Same-cycle preload and read of word 3: read captures the old value.
        load_a(32'h0000_000C, 32'h2222_2222);
        we_a = 1'b1; wadr_a = 32'h0000_000C; wdata_a = 32'h1111_1111;
        bus_a.instr_req = 1'b1; bus_a.instr_adr = 32'h0000_000C;
        @(negedge clk); check("sc_gnt", 32'(bus_a.instr_gnt), 32'd1);
        next();
        we_a = 1'b0; bus_a.instr_req = 1'b0;
        next();
        @(negedge clk);
        check("sc_rvalid", 32'(bus_a.instr_rvalid), 32'd1);
        check("sc_read_old", bus_a.instr_read, 32'h2222_2222);
        next();
        read_a("sc_new", 32'h0000_000C, 32'h1111_1111);

        // dut_b: three grants, reset one cycle before the first response is due.
        for (int c = 0; c < 16; c++) begin
            bus_b.instr_req = (c < 3);
            bus_b.instr_adr = 32'(c + 1) << 2;
            res_b = (c == 7);
            @(negedge clk);
            if (c < 3) check("mf_gnt", 32'(bus_b.instr_gnt), 32'd1);
            check("mf_no_rvalid", 32'(bus_b.instr_rvalid), 32'd0);
            next();
        end
        bus_b.instr_req = 1'b0; res_b = 1'b0;

        // First post-reset request on dut_b answers exactly 8 cycles after grant.
        load_b(32'h0000_0024, 32'h9999_0009);
        bus_b.instr_req = 1'b1; bus_b.instr_adr = 32'h0000_0024;
        @(negedge clk); check("lat8_gnt", 32'(bus_b.instr_gnt), 32'd1);
        next();
        bus_b.instr_req = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk); check("lat8_early", 32'(bus_b.instr_rvalid), 32'd0);
            next();
        end
        @(negedge clk);
        check("lat8_rvalid", 32'(bus_b.instr_rvalid), 32'd1);
        check("lat8_read", bus_b.instr_read, 32'h9999_0009);
        next();
        @(negedge clk); check("lat8_late", 32'(bus_b.instr_rvalid), 32'd0);
        next();

        // Backlog on dut_b: 6 held requests against a 4-deep FIFO.
        for (int i = 0; i < 6; i++) load_b(32'(i) << 2, 32'h0000_0100 + 32'(i));
        k = 0; r = 0;
        for (int c = 0; c < 21; c++) begin
            bus_b.instr_req = (k < 6);
            bus_b.instr_adr = 32'(k) << 2;
            @(negedge clk);
            exp_g  = (k < 6) ? (gcyc[k] == c) : 1'b0;
            exp_rv = (r < 6) ? (rcyc[r] == c) : 1'b0;
            check($sformatf("bl_gnt_c%0d", c), 32'(bus_b.instr_gnt), 32'(exp_g));
            check($sformatf("bl_rvalid_c%0d", c), 32'(bus_b.instr_rvalid), 32'(exp_rv));
            check($sformatf("bl_read_c%0d", c), bus_b.instr_read,
                  exp_rv ? 32'h0000_0100 + 32'(r) : 32'h0);
            if (exp_g)  k++;
            if (exp_rv) r++;
            next();
        end
        bus_b.instr_req = 1'b0;

        // Random traffic on dut_a with concurrent preload writes, scored in order.
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 32'hC0DE_0000 + 32'(i * 7);
            load_a(32'(i) << 2, model_a[i]);
        end
        pending = 1'b0; widx = 0;
        for (int cyc = 0; cyc < 310; cyc++) begin
            if (!pending && cyc < 290) begin
                pending = ($urandom_range(0, 3) != 0);
                widx    = int'($urandom_range(0, 15));
                bus_a.instr_adr = (32'(widx) << 2) | 32'($urandom_range(0, 3));
            end
            bus_a.instr_req = pending;
            we_a    = ($urandom_range(0, 3) == 0);
            wadr_a  = 32'($urandom_range(0, 15)) << 2;
            wdata_a = $urandom();
            @(negedge clk);
            exp_rv = (q.size() > 0) ? (q[0].cyc + 2 == cyc) : 1'b0;
            check("rnd_rvalid", 32'(bus_a.instr_rvalid), 32'(exp_rv));
            check("rnd_read", bus_a.instr_read, exp_rv ? q[0].data : 32'h0);
            if (exp_rv) void'(q.pop_front());
            exp_g = pending;
`ifdef INSTR_MEM_GNT_STALL_EN
            exp_g = exp_g && (lfsr_m[1:0] != 2'b00);
`endif
            check("rnd_gnt", 32'(bus_a.instr_gnt), 32'(exp_g));
            if (exp_g) begin
                q.push_back('{data: model_a[widx], cyc: cyc});
                pending = 1'b0;
            end
            if (we_a) model_a[wadr_a[5:2]] = wdata_a;
            next();
        end
        we_a = 1'b0; bus_a.instr_req = 1'b0;
        check("rnd_drained", 32'(q.size()), 32'd0);
        check("rnd_no_pending", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Memory-side responder for the instruction fetch protocol (req/adr → gnt, then rvalid/read).
- Sits behind the instruction cache's miss port and acts as main instruction memory.
- Holds a word array and accepts up to DEPTH outstanding in-order reads.
- Returns each read a fixed LATENCY cycles after grant, or later under backlog.
- Has a preload write port so the bench and boot logic can fill the memory.

Parameters:
- MEM_LOG_WORDS, 10, log2 of the number of 32-bit words in the array.
- LATENCY, 2, minimum cycles from grant to rvalid. Legal range is 1..15.
- DEPTH, 4, maximum outstanding granted-but-unanswered requests. Must be a power of 2, ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- res  in  1  synchronous active-high reset.
- instr_req  in  1  request valid from the initiator.
- instr_adr  in  32  byte address; bits [1:0] are ignored.
- instr_gnt  out  1  request accepted this cycle.
- instr_rvalid  out  1  response data valid this cycle.
- instr_read  out  32  response data.
- mem_we  in  1  preload write enable.
- mem_wadr  in  32  preload byte address.
- mem_wdata  in  32  preload data.

Behaviour:
- Reset:
  - While res=1 at a rising edge, the FIFO is emptied and all outstanding requests are discarded, including any mid-flight.
  - instr_gnt=0, instr_rvalid=0 and instr_read=0 during and after reset until new traffic arrives.
  - Array contents are not reset. Preload writes in a reset cycle are ignored.
- Word index is instr_adr[MEM_LOG_WORDS+1:2].
- Out of range: any nonzero bit in instr_adr[31:MEM_LOG_WORDS+2] makes the request out of range. It is still granted and answered, with data 32'h0000_0000.
- Grant (combinational): instr_gnt = instr_req && (occupancy < DEPTH) && !res.
  - No pop-through: a full FIFO does not grant, even if the head pops in the same cycle.
  - The initiator holds req/adr stable until gnt.
- Acceptance at the edge ending cycle T:
  - The array word is read and pushed into the FIFO with countdown = LATENCY-1.
  - The data is captured at acceptance. Later writes to that word do not alter it.
- Countdown: each cycle, every valid entry with countdown > 0 decrements by 1.
- Response:
  - instr_rvalid = head valid && head countdown == 0. The head pops at that edge.
  - Earliest rvalid for a request granted in cycle T is cycle T+LATENCY.
- Ordering: strict in order, at most one rvalid per cycle. Back-to-back grants give back-to-back rvalids.
- instr_read = head data when instr_rvalid=1, else 0.
- Occupancy:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter width is clog2(DEPTH)+1.
- Preload:
  - mem_we writes mem_wdata at mem_wadr's index. Out-of-range preload addresses are dropped.
  - A write and an accepted read to the same word in the same cycle: the read captures the OLD value.
- There is no rvalid back-pressure; the initiator must always accept responses.

Optional Feature:
- Macro: INSTR_MEM_GNT_STALL_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1), seeded to 16'hACE1 on reset, advances every cycle.
  - Grant is additionally suppressed when LFSR[1:0]==2'b00, giving random wait states to stress the initiator's gnt handling.
- When undefined: the LFSR logic is absent and grant follows the base rule exactly.
- Response latency rules are unchanged in both cases.

Decomposition:
- Package instr_mem_pkg:
  - word width 32;
  - LFSR seed and taps;
  - a clog2 function;
  - an out-of-range data constant of 32'h0.
- Sub-module instr_mem_resp_fifo: DEPTH-entry FIFO of {data[31:0], countdown[3:0]}, with push/pop, per-entry decrement, head-ready flag and occupancy.
- The top holds the array, grant logic, preload port and LFSR.

Test Plan:
- Preload word 5 = 32'hDEAD_BEEF, LATENCY=2. Req adr 32'h14 in cycle 10 → gnt in cycle 10; rvalid with read=DEAD_BEEF in cycle 12 only.
- DEPTH=4, LATENCY=8, req held high with 6 distinct addresses → gnts in cycles 0-3, no gnt in cycles 4-7. A gnt follows the cycle after the first pop (cycle 8). All data is returned in order.
- Req adr 32'h8000_0000 (out of range, MEM_LOG_WORDS=10) → granted; rvalid with read=0 after LATENCY cycles.
- Same-cycle preload of word 3 = 32'h1111_1111 (old 32'h2222_2222) and accepted read of adr 32'hC → response 32'h2222_2222. A later read returns 32'h1111_1111.
- Three requests granted, res asserted 1 cycle before the first rvalid → no rvalid ever appears for them. The first post-reset request returns after exactly LATENCY cycles.
- With INSTR_MEM_GNT_STALL_EN, 1000 random requests → gnt is never asserted when LFSR[1:0]==0. Every granted request gets exactly one rvalid, in order.
